// File: rtl/program_counter_ras_if.sv
// Bundles the PC control inputs and the PC/RAS status outputs into one port.
// No latency of its own: plain wires between the control side and the PC.
// No flow control; the control side holds the PC with its stall signal.
interface program_counter_ras_if #(
  parameter int WIDTH     = 64,
  parameter int COND_W    = 19,
  parameter int UNCOND_W  = 26,
  parameter int RAS_DEPTH = 8
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic                stall;
  logic [2:0]          pc_op;
  logic                br_taken;
  logic [COND_W-1:0]   cond_addr;
  logic [UNCOND_W-1:0] br_addr;
  logic [WIDTH-1:0]    reg_target;
  logic [WIDTH-1:0]    program_index;
  logic [WIDTH-1:0]    link_addr;
  logic [CNT_W-1:0]    ras_count;
  logic                ras_overflow;
  logic                misalign;

  // Control/decode side: issues the op and observes the PC.
  modport master (
    output stall, pc_op, br_taken, cond_addr, br_addr, reg_target,
    input  program_index, link_addr, ras_count, ras_overflow, misalign
  );

  // Program counter side.
  modport slave (
    input  stall, pc_op, br_taken, cond_addr, br_addr, reg_target,
    output program_index, link_addr, ras_count, ras_overflow, misalign
  );
endinterface

// File: rtl/program_counter_ras.sv
// Fetch program counter with branch, branch-with-link, indirect branch and return-address stack.
// One-cycle latency: the next PC is loaded on the clock edge; link_addr is combinational from the PC.
// stall holds the PC, the RAS and the misalign flag; the op presented during a stall is dropped.
module program_counter_ras #(
  parameter int                WIDTH      = 64,
  parameter int                INCR       = 4,
  parameter int                COND_W     = 19,
  parameter int                UNCOND_W   = 26,
  parameter int                RAS_DEPTH  = 8,
  parameter logic [WIDTH-1:0]  RESET_ADDR = '0
) (
  input logic                 clk,
  input logic                 reset,
  program_counter_ras_if.slave bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    OP_SEQ    = 3'd0,
    OP_COND   = 3'd1,
    OP_UNCOND = 3'd2,
    OP_BL     = 3'd3,
    OP_BR     = 3'd4,
    OP_RET    = 3'd5
  } op_e;

  logic [WIDTH-1:0] pc_q;
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             misalign_q;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  logic [WIDTH-1:0] link;
  logic [WIDTH-1:0] cond_off;
  logic [WIDTH-1:0] uncond_off;
  logic [WIDTH-1:0] next_pc;
  logic [PTR_W-1:0] ptr_dec;
  logic             ras_full;
  logic             ras_empty;
  logic             push;
  logic             pop;

  assign link       = pc_q + WIDTH'(INCR);
  // Immediates are word offsets: sign-extend, then append two zero bits for the byte offset.
  assign cond_off   = {{(WIDTH-COND_W-2){bus.cond_addr[COND_W-1]}}, bus.cond_addr, 2'b00};
  assign uncond_off = {{(WIDTH-UNCOND_W-2){bus.br_addr[UNCOND_W-1]}}, bus.br_addr, 2'b00};
  assign ptr_dec    = ptr_q - PTR_W'(1);
  assign ras_full   = (count_q == CNT_W'(RAS_DEPTH));
  assign ras_empty  = (count_q == '0);

  // Next-PC selection and RAS push/pop decode; a RET on an empty stack falls back to reg_target.
  always_comb begin
    next_pc = link;
    push    = 1'b0;
    pop     = 1'b0;
    case (bus.pc_op)
      OP_COND:   next_pc = bus.br_taken ? pc_q + cond_off : link;
      OP_UNCOND: next_pc = pc_q + uncond_off;
      OP_BL: begin
        next_pc = pc_q + uncond_off;
        push    = 1'b1;
      end
      OP_BR:     next_pc = bus.reg_target;
      OP_RET: begin
        if (ras_empty) begin
          next_pc = bus.reg_target;
        end else begin
          next_pc = ras_mem[ptr_dec];
          pop     = 1'b1;
        end
      end
      default:   next_pc = link;
    endcase
  end

  // PC, stack pointer, occupancy and status flags; everything freezes while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_ADDR;
      ptr_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      misalign_q <= 1'b0;
    end else if (!bus.stall) begin
      pc_q       <= next_pc;
      misalign_q <= (next_pc[1:0] != 2'b00);
      if (push) begin
        // A full circular stack overwrites its oldest entry; the pointer still advances.
        ptr_q <= ptr_q + PTR_W'(1);
        if (ras_full) begin
          overflow_q <= 1'b1;
        end else begin
          count_q <= count_q + CNT_W'(1);
        end
      end else if (pop) begin
        ptr_q   <= ptr_dec;
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Stack storage; entries beyond the valid count are never read, so no reset is needed.
  always_ff @(posedge clk) begin
    if (!bus.stall && push) begin
      ras_mem[ptr_q] <= link;
    end
  end

  assign bus.program_index = pc_q;
  assign bus.link_addr     = link;
  assign bus.ras_count     = count_q;
  assign bus.ras_overflow  = overflow_q;
  assign bus.misalign      = misalign_q;
endmodule

// File: tb/tb_program_counter_ras.sv
// Self-checking bench for program_counter_ras: directed scenarios plus randomized ops vs a queue-based model.
// Outputs are sampled 1 time unit after the rising edge.
// The model treats the RAS as a bounded LIFO queue that drops its oldest entry on overflow.
module tb_program_counter_ras;
  localparam int WIDTH     = 64;
  localparam int COND_W    = 19;
  localparam int UNCOND_W  = 26;
  localparam int RAS_DEPTH = 8;

  logic clk;
  logic reset;

  program_counter_ras_if #(
    .WIDTH(WIDTH), .COND_W(COND_W), .UNCOND_W(UNCOND_W), .RAS_DEPTH(RAS_DEPTH)
  ) bus ();

  program_counter_ras #(
    .WIDTH(WIDTH), .INCR(4), .COND_W(COND_W), .UNCOND_W(UNCOND_W),
    .RAS_DEPTH(RAS_DEPTH), .RESET_ADDR('0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [WIDTH-1:0] m_pc;
  logic [WIDTH-1:0] m_ras[$];
  logic             m_ovf;
  logic             m_mis;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_pc = '0;
    m_ras.delete();
    m_ovf = 1'b0;
    m_mis = 1'b0;
  endtask

  task automatic model_update(input logic [2:0] op, input logic tk, input logic [COND_W-1:0] ca,
                              input logic [UNCOND_W-1:0] ba, input logic [WIDTH-1:0] rt,
                              input logic st);
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] lk;
    if (st) return;
    lk = m_pc + 64'd4;
    case (op)
      3'd1: nxt = tk ? m_pc + 64'($signed(ca)) * 64'd4 : lk;
      3'd2: nxt = m_pc + 64'($signed(ba)) * 64'd4;
      3'd3: begin
        nxt = m_pc + 64'($signed(ba)) * 64'd4;
        m_ras.push_back(lk);
        if (m_ras.size() > RAS_DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
      end
      3'd4: nxt = rt;
      3'd5: nxt = (m_ras.size() > 0) ? m_ras.pop_back() : rt;
      default: nxt = lk;
    endcase
    m_pc  = nxt;
    m_mis = (nxt[1:0] != 2'b00);
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".pc"},   bus.program_index, m_pc);
    check({tag, ".link"}, bus.link_addr, m_pc + 64'd4);
    check({tag, ".cnt"},  64'(bus.ras_count), 64'(m_ras.size()));
    check({tag, ".ovf"},  64'(bus.ras_overflow), 64'(m_ovf));
    check({tag, ".mis"},  64'(bus.misalign), 64'(m_mis));
  endtask

  task automatic step(input string tag, input logic [2:0] op, input logic tk,
                      input logic [COND_W-1:0] ca, input logic [UNCOND_W-1:0] ba,
                      input logic [WIDTH-1:0] rt, input logic st);
    bus.pc_op      = op;
    bus.br_taken   = tk;
    bus.cond_addr  = ca;
    bus.br_addr    = ba;
    bus.reg_target = rt;
    bus.stall      = st;
    @(posedge clk);
    model_update(op, tk, ca, ba, rt, st);
    #1;
    compare_all(tag);
  endtask

  logic [WIDTH-1:0] base;

  initial begin
    reset          = 1'b0;
    bus.stall      = 1'b0;
    bus.pc_op      = 3'd0;
    bus.br_taken   = 1'b0;
    bus.cond_addr  = '0;
    bus.br_addr    = '0;
    bus.reg_target = '0;
    model_reset();
    #3;
    check("rst.pc",  bus.program_index, 64'd0);
    check("rst.cnt", 64'(bus.ras_count), 64'd0);
    check("rst.ovf", 64'(bus.ras_overflow), 64'd0);
    check("rst.mis", 64'(bus.misalign), 64'd0);
    #9 reset = 1'b1;

    // Three sequential steps from reset.
    for (int i = 1; i <= 3; i++) begin
      step("seq", 3'd0, 1'b1, '0, '0, '0, 1'b0);
      check("seq.pc", bus.program_index, 64'(4 * i));
    end
    check("seq.link", bus.link_addr, 64'd16);

    // Conditional and unconditional branches from PC=100.
    step("br100", 3'd4, 1'b0, '0, '0, 64'd100, 1'b0);
    step("cond_t", 3'd1, 1'b1, 19'h7FFFE, '0, '0, 1'b0);
    check("cond_t.pc", bus.program_index, 64'd92);
    step("br100b", 3'd4, 1'b0, '0, '0, 64'd100, 1'b0);
    step("cond_nt", 3'd1, 1'b0, 19'h7FFFE, '0, '0, 1'b0);
    check("cond_nt.pc", bus.program_index, 64'd104);
    step("uncond", 3'd2, 1'b1, '0, 26'd5, '0, 1'b0);
    check("uncond.pc", bus.program_index, 64'd124);

    // BL then RET.
    step("br40", 3'd4, 1'b0, '0, '0, 64'd40, 1'b0);
    step("bl", 3'd3, 1'b0, '0, 26'd10, '0, 1'b0);
    check("bl.pc", bus.program_index, 64'd80);
    check("bl.cnt", 64'(bus.ras_count), 64'd1);
    step("ret", 3'd5, 1'b0, '0, '0, 64'hDEAD0, 1'b0);
    check("ret.pc", bus.program_index, 64'd44);
    check("ret.cnt", 64'(bus.ras_count), 64'd0);

    // Nine nested BLs overflow the stack; eight RETs return the newest links.
    base = 64'h1000;
    step("br1000", 3'd4, 1'b0, '0, '0, base, 1'b0);
    for (int i = 0; i < 9; i++) step("nest", 3'd3, 1'b0, '0, 26'd1, '0, 1'b0);
    check("nest.cnt", 64'(bus.ras_count), 64'd8);
    check("nest.ovf", 64'(bus.ras_overflow), 64'd1);
    for (int k = 0; k < 8; k++) begin
      step("unwind", 3'd5, 1'b0, '0, '0, 64'h7770, 1'b0);
      check("unwind.pc", bus.program_index, base + 64'(4 * (9 - k)));
    end
    check("unwind.cnt", 64'(bus.ras_count), 64'd0);

    // Empty-stack RET falls back to reg_target; misaligned BR target.
    step("ret_empty", 3'd5, 1'b0, '0, '0, 64'h200, 1'b0);
    check("ret_empty.pc", bus.program_index, 64'h200);
    check("ret_empty.cnt", 64'(bus.ras_count), 64'd0);
    step("br_mis", 3'd4, 1'b0, '0, '0, 64'h1002, 1'b0);
    check("br_mis.mis", 64'(bus.misalign), 64'd1);

    // Stalled BL for two cycles changes nothing.
    step("br300", 3'd4, 1'b0, '0, '0, 64'h300, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step("stall", 3'd3, 1'b1, '0, 26'd7, 64'h55, 1'b1);
      check("stall.pc", bus.program_index, 64'h300);
      check("stall.cnt", 64'(bus.ras_count), 64'd0);
    end
    check("stall.link", bus.link_addr, 64'h304);

    // Asynchronous reset pulse between clock edges.
    step("pre_rst", 3'd3, 1'b0, '0, 26'd3, '0, 1'b0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("arst.pc",  bus.program_index, 64'd0);
    check("arst.cnt", 64'(bus.ras_count), 64'd0);
    check("arst.ovf", 64'(bus.ras_overflow), 64'd0);
    #1 reset = 1'b1;

    // Randomized ops against the model.
    for (int i = 0; i < 400; i++) begin
      logic [WIDTH-1:0] rt;
      rt = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
      step("rnd", 3'($urandom_range(0, 7)), 1'($urandom), 19'($urandom), 26'($urandom),
           rt, ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
